// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port word arbiter in front of the single SRAM controller
//
// Purpose:
//   Port 0 (MEM-stage data) and port 1 (instruction/aux) share one SRAM
//   controller. One request at a time is latched into the mem_* registers,
//   the controller's ready handshake is followed to completion, read data is
//   captured for the granted port and that port sees ready=1 for one cycle.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate using
//                        rr_last; when undefined, port 0 has fixed priority.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pN_rd_en / pN_wr_en       level requests, held until the port's ready pulse
//   pN_addr / pN_wdata        request address and write data (sampled in IDLE)
//   pN_rdata                  registered read data, held until the next read
//   pN_ready                  low while the port requests and is not being completed
//   mem_rd_en / mem_wr_en     enables to the controller
//   mem_addr / mem_wdata      address / write data to the controller
//   mem_rdata / mem_ready     read data / ready from the controller

module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd_en,
  input  logic              p0_wr_en,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_rd_en,
  input  logic              p1_wr_en,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;

  logic                p0_req;
  logic                p1_req;
  logic                grant;       // port selected in IDLE: 0 or 1
  logic                grant_wr;
  logic                grant_rd;

  assign p0_req = p0_rd_en | p0_wr_en;
  assign p1_req = p1_rd_en | p1_wr_en;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q;

  // On contention the port that was not granted last wins; a lone requester
  // always wins.
  always_comb begin
    grant = ~p0_req;
    if (p0_req && p1_req) begin
      grant = ~rr_last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else if (state_q == ST_IDLE && (p0_req || p1_req)) begin
      rr_last_q <= grant;
    end
  end
`else
  // Fixed priority: port 1 only when port 0 is silent.
  assign grant = ~p0_req;
`endif

  // Write wins when a port raises both enables.
  assign grant_wr = grant ? p1_wr_en : p0_wr_en;
  assign grant_rd = ~grant_wr & (grant ? p1_rd_en : p0_rd_en);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_rd_en_d = mem_rd_en_q;
    mem_wr_en_d = mem_wr_en_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        if (p0_req || p1_req) begin
          owner_d     = grant;
          mem_wr_en_d = grant_wr;
          mem_rd_en_d = grant_rd;
          mem_addr_d  = grant ? p1_addr  : p0_addr;
          mem_wdata_d = grant ? p1_wdata : p0_wdata;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Controller drops ready once it has taken the access.
        if (!mem_ready) begin
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (mem_ready) begin
          if (mem_rd_en_q) begin
            if (owner_q) begin
              p1_rdata_d = mem_rdata;
            end else begin
              p0_rdata_d = mem_rdata;
            end
          end
          mem_rd_en_d = 1'b0;
          mem_wr_en_d = 1'b0;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        // Enables stay low for this turnaround so the controller settles in
        // idle before any further access is presented.
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

  // A port that is not requesting is never stalled; a requesting port is
  // released only in the DONE cycle of its own access.
  assign p0_ready = ~p0_req | ((state_q == ST_DONE) & ~owner_q);
  assign p1_ready = ~p1_req | ((state_q == ST_DONE) &  owner_q);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter

module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_rd_en = 1'b0, p0_wr_en = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic [31:0] p0_rdata;
  logic        p0_ready;
  logic        p1_rd_en = 1'b0, p1_wr_en = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic [31:0] p1_rdata;
  logic        p1_ready;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int errors = 0;
  int checks = 0;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Controller model: ready drops the cycle after an enable is seen, rises
  // four cycles later with the access performed, then one turnaround cycle.
  logic [31:0] mem [0:1023];
  logic        ctl_busy;
  int          ctl_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b1;
      ctl_busy  <= 1'b0;
      ctl_cnt   <= 0;
      mem_rdata <= '0;
    end else if (!ctl_busy) begin
      if (mem_rd_en || mem_wr_en) begin
        ctl_busy  <= 1'b1;
        mem_ready <= 1'b0;
        ctl_cnt   <= 3;
      end
    end else if (!mem_ready) begin
      if (ctl_cnt == 0) begin
        mem_ready <= 1'b1;
        if (mem_wr_en) mem[mem_addr[11:2]] <= mem_wdata;
        else           mem_rdata <= mem[mem_addr[11:2]];
      end else begin
        ctl_cnt <= ctl_cnt - 1;
      end
    end else begin
      ctl_busy <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin errors++;
      $display("FAIL reset_enables: got rd=%b wr=%b expected 0 0", mem_rd_en, mem_wr_en); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata); end
    checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_rdata: got %h %h expected 0 0", p0_rdata, p1_rdata); end
    checks++; if (p0_ready !== 1'b1 || p1_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b %b expected 1 1", p0_ready, p1_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic exp_en, exp_rdy;
    p0_wr_en = 1'b1; p0_addr = 32'h400; p0_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_en  = (k <= 6);
      exp_rdy = (k == 7);
      checks++; if (mem_wr_en !== exp_en || mem_rd_en !== 1'b0) begin errors++;
        $display("FAIL wr_enable c%0d: got wr=%b rd=%b expected wr=%b rd=0", k, mem_wr_en, mem_rd_en, exp_en); end
      checks++; if (p0_ready !== exp_rdy) begin errors++;
        $display("FAIL wr_ready c%0d: got %b expected %b", k, p0_ready, exp_rdy); end
      if (k == 1) begin
        checks++; if (mem_addr !== 32'h400 || mem_wdata !== 32'hDEADBEEF) begin errors++;
          $display("FAIL wr_bus: got addr=%h data=%h expected 400 deadbeef", mem_addr, mem_wdata); end
      end
    end
    p0_wr_en = 1'b0;
    step();
    checks++; if (mem[10'h100] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL wr_memory: got %h expected deadbeef", mem[10'h100]); end
    p0_rd_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++; if (mem_rd_en !== (k <= 6)) begin errors++;
        $display("FAIL rd_enable c%0d: got %b", k, mem_rd_en); end
    end
    checks++; if (p0_ready !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rd_data: got ready=%b data=%h expected 1 deadbeef", p0_ready, p0_rdata); end
    p0_rd_en = 1'b0;
    step(); step();
    checks++; if (p0_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rd_hold: got %h expected deadbeef", p0_rdata); end
  endtask

  task automatic test_port1_read();
    int p0_stalls = 0;
    p1_rd_en = 1'b1; p1_addr = 32'h408;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (p0_ready !== 1'b1) p0_stalls++;
      if (k < 7) begin
        checks++; if (p1_ready !== 1'b0) begin errors++;
          $display("FAIL p1_stall c%0d: got %b expected 0", k, p1_ready); end
      end
    end
    checks++; if (p1_ready !== 1'b1 || p1_rdata !== 32'h12345678) begin errors++;
      $display("FAIL p1_read: got ready=%b data=%h expected 1 12345678", p1_ready, p1_rdata); end
    checks++; if (p0_stalls !== 0) begin errors++;
      $display("FAIL p1_p0_ready: got %0d stalled cycles expected 0", p0_stalls); end
    checks++; if (p0_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL p1_p0_rdata: got %h expected deadbeef", p0_rdata); end
    p1_rd_en = 1'b0;
    step();
  endtask

  task automatic test_wr_rd_both();
    p0_wr_en = 1'b1; p0_rd_en = 1'b1; p0_addr = 32'h410; p0_wdata = 32'hA5A5A5A5;
    step();
    checks++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin errors++;
      $display("FAIL both_op: got wr=%b rd=%b expected 1 0", mem_wr_en, mem_rd_en); end
    for (int k = 2; k <= 7; k++) step();
    checks++; if (p0_ready !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL both_done: got ready=%b data=%h expected 1 deadbeef", p0_ready, p0_rdata); end
    p0_wr_en = 1'b0; p0_rd_en = 1'b0;
    step();
    p0_rd_en = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    checks++; if (p0_ready !== 1'b1 || p0_rdata !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL both_readback: got ready=%b data=%h expected 1 a5a5a5a5", p0_ready, p0_rdata); end
    p0_rd_en = 1'b0;
    step();
  endtask

  task automatic test_arbitration();
    int exp_g [3];
    int seen;
    bit got;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0};
`else
    exp_g = '{0, 0, 0};
`endif
    p0_rd_en = 1'b1; p0_addr = 32'h400;
    p1_rd_en = 1'b1; p1_addr = 32'h408;
    for (int g = 0; g < 3; g++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        step();
        if (p0_ready || p1_ready) got = 1'b1;
      end
      checks++; if (!got) begin errors++;
        $display("FAIL arb_timeout g%0d: got no ready expected a grant", g); end
      checks++; if (p0_ready && p1_ready) begin errors++;
        $display("FAIL arb_exclusive g%0d: got both ready expected one", g); end
      seen = p1_ready ? 1 : 0;
      checks++; if (seen !== exp_g[g]) begin errors++;
        $display("FAIL arb_grant g%0d: got port %0d expected port %0d", g, seen, exp_g[g]); end
      checks++;
      if ((seen == 0 && p0_rdata !== 32'hDEADBEEF) || (seen == 1 && p1_rdata !== 32'h12345678)) begin
        errors++;
        $display("FAIL arb_data g%0d: got %h %h", g, p0_rdata, p1_rdata); end
    end
    p0_rd_en = 1'b0;
    p1_rdata_clear_check: begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        step();
        if (p1_ready) got = 1'b1;
      end
      checks++; if (!got || p1_rdata !== 32'h12345678) begin errors++;
        $display("FAIL arb_p1_after: got ready=%b data=%h expected 1 12345678", p1_ready, p1_rdata); end
    end
    p1_rd_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    p0_wr_en = 1'b1; p0_addr = 32'h420; p0_wdata = 32'h11111111;
    for (int k = 1; k <= 4; k++) step();
    checks++; if (mem_wr_en !== 1'b1) begin errors++;
      $display("FAIL rstmid_pre: got wr=%b expected 1", mem_wr_en); end
    rst = 1'b1;
    #1;
    checks++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin errors++;
      $display("FAIL rstmid_async: got wr=%b rd=%b expected 0 0", mem_wr_en, mem_rd_en); end
    checks++; if (p0_ready !== 1'b0) begin errors++;
      $display("FAIL rstmid_noready: got %b expected 0", p0_ready); end
    p0_wr_en = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (mem_wr_en || mem_rd_en) stray++;
    end
    checks++; if (stray !== 0) begin errors++;
      $display("FAIL rstmid_idle: got %0d enabled cycles expected 0", stray); end
    p0_rd_en = 1'b1; p0_addr = 32'h400;
    step();
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h400) begin errors++;
      $display("FAIL rstmid_restart: got rd=%b addr=%h expected 1 400", mem_rd_en, mem_addr); end
    for (int k = 2; k <= 7; k++) step();
    checks++; if (p0_ready !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rstmid_after: got ready=%b data=%h expected 1 deadbeef", p0_ready, p0_rdata); end
    p0_rd_en = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_en, exp_rdy;
    p0_rd_en = 1'b1; p0_addr = 32'h408;
    for (int k = 1; k <= 15; k++) begin
      step();
      exp_en  = (k <= 6) || (k >= 9 && k <= 14);
      exp_rdy = (k == 7) || (k == 15);
      checks++; if (mem_rd_en !== exp_en) begin errors++;
        $display("FAIL b2b_enable c%0d: got %b expected %b", k, mem_rd_en, exp_en); end
      checks++; if (p0_ready !== exp_rdy) begin errors++;
        $display("FAIL b2b_ready c%0d: got %b expected %b", k, p0_ready, exp_rdy); end
    end
    checks++; if (p0_rdata !== 32'h12345678) begin errors++;
      $display("FAIL b2b_data: got %h expected 12345678", p0_rdata); end
    p0_rd_en = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h102] = 32'h12345678;
    test_reset();
    step();
    test_write_read();
    test_port1_read();
    test_wr_rd_both();
    test_arbitration();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
